// File: rtl/mem_stage.sv
// mem_stage: RV64 memory-access stage with byte-lane alignment, load extension and req/ack stalling
// Ports: execute-side in* controls/operands, stall back to upstream,
//        mem* req/ack data-memory port, out* write-back slot (outData also feeds forwarding).
module mem_stage #(
  parameter int BUS_DATA_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      inValid,
  input  logic                      inMemRead,
  input  logic                      inMemWrite,
  input  logic                      inMemOrReg,
  input  logic                      inRegWrite,
  input  logic [4:0]                inRd,
  input  logic [2:0]                inFunct3,
  input  logic [BUS_DATA_WIDTH-1:0] inResult,
  input  logic [BUS_DATA_WIDTH-1:0] inStoreData,
  output logic                      stall,
  output logic                      memReq,
  output logic                      memWe,
  output logic [BUS_DATA_WIDTH-1:0] memAddr,
  output logic [BUS_DATA_WIDTH-1:0] memWdata,
  output logic [7:0]                memWstrb,
  input  logic                      memAck,
  input  logic [BUS_DATA_WIDTH-1:0] memRdata,
  output logic                      outValid,
  output logic                      outRegWrite,
  output logic [4:0]                outRd,
  output logic [BUS_DATA_WIDTH-1:0] outData,
  output logic                      outMisaligned
);
  localparam int W = BUS_DATA_WIDTH;
  typedef enum logic {IDLE, REQ} state_t;
  state_t state_q, state_d;
  logic [W-1:0] res_q, res_d, wdata_q, wdata_d, odata_q, odata_d, raw, ext;
  logic [7:0] wstrb_q, wstrb_d, strb;
  logic [4:0] rd_q, rd_d, ord_q, ord_d;
  logic [2:0] f3_q, f3_d, off;
  logic we_q, we_d, rw_q, rw_d, mor_q, mor_d;
  logic ovalid_q, ovalid_d, orw_q, orw_d, omis_q, omis_d;
  logic mem_op, mis, go;
  assign off    = inResult[2:0];
  assign mem_op = inMemRead | inMemWrite;
  // unused funct3 encodings fold into the misaligned path so they never reach the bus
  assign mis = (inMemWrite ? inFunct3[2] : inFunct3 == 3'b111)
             | (inFunct3[1:0] == 2'd1 & off[0])
             | (inFunct3[1:0] == 2'd2 & |off[1:0])
             | (inFunct3[1:0] == 2'd3 & |off);
  assign go    = state_q == IDLE & inValid & mem_op & ~mis;
  assign stall = go | state_q == REQ;
  assign strb = inFunct3[1:0] == 2'd0 ? 8'h01 << off :
                inFunct3[1:0] == 2'd1 ? 8'h03 << off :
                inFunct3[1:0] == 2'd2 ? 8'h0F << off : 8'hFF;
  assign raw = memRdata >> {res_q[2:0], 3'b000};
  always_comb begin
    ext = raw;
    case (f3_q)
      3'b000: ext = {{(W-8){raw[7]}}, raw[7:0]};
      3'b001: ext = {{(W-16){raw[15]}}, raw[15:0]};
      3'b010: ext = {{(W-32){raw[31]}}, raw[31:0]};
      3'b100: ext = {{(W-8){1'b0}}, raw[7:0]};
      3'b101: ext = {{(W-16){1'b0}}, raw[15:0]};
      3'b110: ext = {{(W-32){1'b0}}, raw[31:0]};
      default: ext = raw;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    we_d     = we_q;
    rw_d     = rw_q;
    mor_d    = mor_q;
    rd_d     = rd_q;
    f3_d     = f3_q;
    ovalid_d = 1'b0;
    orw_d    = 1'b0;
    omis_d   = 1'b0;
    ord_d    = ord_q;
    odata_d  = odata_q;
    if (state_q == IDLE) begin
      if (inValid & ~go) begin
        ovalid_d = 1'b1;
        orw_d    = ~mem_op & inRegWrite;
        omis_d   = mem_op;
        ord_d    = inRd;
        odata_d  = mem_op ? '0 : inResult;
      end
      if (go) begin
        state_d = REQ;
        res_d   = inResult;
        wdata_d = inStoreData << {off, 3'b000};
        wstrb_d = inMemWrite ? strb : 8'h00;
        we_d    = inMemWrite;
        rw_d    = inRegWrite;
        mor_d   = inMemOrReg;
        rd_d    = inRd;
        f3_d    = inFunct3;
      end
    end else if (memAck) begin
      state_d  = IDLE;
      ovalid_d = 1'b1;
      orw_d    = ~we_q & rw_q;
      ord_d    = rd_q;
      odata_d  = we_q ? '0 : (mor_q ? ext : res_q);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      res_q    <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      we_q     <= 1'b0;
      rw_q     <= 1'b0;
      mor_q    <= 1'b0;
      rd_q     <= '0;
      f3_q     <= '0;
      ovalid_q <= 1'b0;
      orw_q    <= 1'b0;
      omis_q   <= 1'b0;
      ord_q    <= '0;
      odata_q  <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      we_q     <= we_d;
      rw_q     <= rw_d;
      mor_q    <= mor_d;
      rd_q     <= rd_d;
      f3_q     <= f3_d;
      ovalid_q <= ovalid_d;
      orw_q    <= orw_d;
      omis_q   <= omis_d;
      ord_q    <= ord_d;
      odata_q  <= odata_d;
    end
  end
  assign memReq        = state_q == REQ;
  assign memWe         = we_q;
  assign memAddr       = {res_q[W-1:3], 3'b000};
  assign memWdata      = wdata_q;
  assign memWstrb      = wstrb_q;
  assign outValid      = ovalid_q;
  assign outRegWrite   = orw_q;
  assign outMisaligned = omis_q;
  assign outRd         = ord_q;
  assign outData       = odata_q;
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 64-bit RV64IM pipeline. It sits between the execute-stage ALU outputs and write-back. It turns ALU-computed addresses and store data into byte-lane-aligned requests on a req/ack data-memory port, sign- or zero-extends load data, and stalls upstream while an access is outstanding. It also presents the result that feeds back into the execute stage's forwarding mux (`inMemResult`).

## Interface
- `BUS_DATA_WIDTH`, 64: datapath and memory word width (fixed at 64; 8 byte lanes).
- `clk` in 1: single clock; all state changes on posedge.
- `reset_n` in 1: asynchronous, active-low reset.
- `inValid` in 1: execute stage presents an instruction this cycle.
- `inMemRead` / `inMemWrite` in 1 each: load / store; never both set.
- `inMemOrReg` in 1: 1 = write-back data comes from memory, 0 = from ALU result.
- `inRegWrite` in 1: instruction writes `inRd`.
- `inRd` in 5: destination register.
- `inFunct3` in 3: access size and sign.
  - Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU.
  - Stores: 000 SB, 001 SH, 010 SW, 011 SD.
- `inResult` in 64: ALU result; this is the byte address for memory operations.
- `inStoreData` in 64: forwarded rs2 value for stores.
- `stall` out 1: upstream must hold its inputs while high.
- `memReq` out 1: request valid; held until `memAck`.
- `memWe` out 1: 1 = write.
- `memAddr` out 64: `{inResult[63:3], 3'b000}`.
- `memWdata` out 64: store data shifted into its byte lanes.
- `memWstrb` out 8: byte enables; 0 for reads.
- `memAck` in 1: completes the outstanding request this cycle.
- `memRdata` in 64: read data; valid when `memAck` is high and the request is a read.
- `outValid` out 1: write-back slot valid.
- `outRegWrite` out 1: write-back enable (already gated by `outValid` and `outMisaligned`).
- `outRd` out 5: write-back register.
- `outData` out 64: write-back value; also drives the execute stage's `inMemResult`.
- `outMisaligned` out 1: the accepted memory op was misaligned and was not issued.

## Operation
- FSM states: IDLE, REQ.
- Offset definition: `off = inResult[2:0]`.
- Misalignment test:
  - Halfword: `off[0] != 0`.
  - Word: `off[1:0] != 0`.
  - Doubleword: `off != 0`.
  - Byte accesses are never misaligned.
- IDLE, `inValid`, not a memory op: register the write-back fields with `outData = inResult`, `outValid = 1`. No stall.
- IDLE, `inValid`, misaligned memory op:
  - `outValid = 1`, `outMisaligned = 1`, `outRegWrite = 0`, `outData = 0`.
  - No request is issued and `stall` is not raised.
- IDLE, `inValid`, aligned memory op:
  - `stall` is driven high combinationally in the same cycle.
  - Address, strobes, shifted data, `inRd`, `inFunct3`, `off` and control are latched; go to REQ.
  - `outValid` is 0 on the next cycle.
- REQ:
  - `memReq = 1` with stable address, data and strobes.
  - `stall = 1`, including the ack cycle. Inputs are not sampled.
  - On `memAck`: go to IDLE and register write-back.
    - Loads: `outData` = extracted and extended data.
    - Stores: `outData = 0`, `outRegWrite = 0`.
- Store lanes:
  - `memWdata = inStoreData << (8*off)`.
  - `memWstrb` = SB `8'b1 << off`, SH `8'b11 << off`, SW `8'hF << off`, SD `8'hFF`.
- Load extraction:
  - `raw = memRdata >> (8*off)`.
  - Take the low 8/16/32/64 bits.
  - Sign-extend for LB/LH/LW; zero-extend for LBU/LHU/LWU; LD takes all 64 bits.
- Unused `inFunct3` codes (load 111, store 1xx) are treated as misaligned.
- `memAck` while in IDLE is ignored.
- `outValid` is a single-cycle pulse per instruction; when no instruction completes, `outValid = 0` and `outRegWrite = 0`.

## Timing
- Reset values (asynchronous, immediate):
  - State IDLE.
  - `memReq`, `memWe`, `memWstrb`, `memAddr`, `memWdata` = 0.
  - `outValid`, `outRegWrite`, `outMisaligned`, `outRd`, `outData` = 0.
  - `stall` = 0.
- Reset asserted in REQ drops `memReq` the same instant. The access is abandoned and no write-back occurs.
- Non-memory instruction: accepted at edge N, `outValid` high in cycle N+1.
- Memory op accepted at edge N:
  - `memReq` high from N+1.
  - Ack in cycle N+k means `outValid` is high in N+k+1 and the FSM is back in IDLE in N+k+1.
  - `stall` can fall in N+k+1 at the earliest.
  - Minimum total latency is 2 cycles (ack in the first REQ cycle).
- Ack in the same cycle `memReq` first rises is legal and completes the request.
- Back-to-back memory ops: the next op is accepted in the first IDLE cycle. `memReq` therefore drops for exactly one cycle between requests.

## Test plan
- Reset mid-request: LD issued, `reset_n` low in REQ before ack → `memReq` = 0 immediately, no `outValid`, state IDLE after release.
- Load 0xFFFF_FFFF_8000_0000 at `off` 4 with zero-wait ack:
  - LW → `outData` = 0xFFFF_FFFF_FFFF_FFFF.
  - LWU → 0x0000_0000_FFFF_FFFF.
  - `outValid` 2 cycles after accept.
- SB of 0xAB to address 0x1005 → `memAddr` = 0x1000, `memWstrb` = 8'b0010_0000, `memWdata[47:40]` = 0xAB, `memWe` = 1; completion gives `outRegWrite` = 0.
- LH at address 0x1003 → `outMisaligned` = 1, `memReq` never rises, `stall` stays 0, `outRegWrite` = 0.
- LD with ack delayed 5 cycles:
  - `stall` high for 6 cycles (the accept cycle plus 5 REQ cycles).
  - Address and data stable throughout REQ.
  - Spurious ack while IDLE beforehand is ignored.
- ADD result 0x1234 followed by SD, then LBU at `off` 7 → ALU result on `outData` after 1 cycle, then SD completes, then `memReq` gap of exactly 1 cycle, then LBU returns byte 7 zero-extended.
